// File: rtl/button_press_classifier_if.sv
// Button classifier bus: upstream edge pulses and time base in, classified press pulses out.
// state_dbg mirrors the classifier FSM state so checkers can observe it.
interface button_press_classifier_if;
    logic       tick;
    logic       pedge;
    logic       nedge;
    logic       short_press;
    logic       long_press;
    logic       repeat_press;
    logic       held;
    logic [1:0] state_dbg;

    // Inputs are single-cycle pulses sampled on the rising clk edge; outputs are
    // registered pulses/levels valid one cycle after the qualifying input cycle.
    modport master (
        output tick, pedge, nedge,
        input  short_press, long_press, repeat_press, held, state_dbg
    );

    modport slave (
        input  tick, pedge, nedge,
        output short_press, long_press, repeat_press, held, state_dbg
    );
endinterface

// File: rtl/button_press_classifier.sv
// Classifies a debounced button into short, long and (optionally) auto-repeat presses.
// Optional feature macro: REPEAT_PRESS_EN enables the auto-repeat counter and repeat_press.
module button_press_classifier #(
    parameter int LONG_MS   = 1000,
    parameter int REPEAT_MS = 200
) (
    input  logic                        clk,
    input  logic                        reset,
    button_press_classifier_if.slave    bus
);
    localparam int MAX_MS = (LONG_MS > REPEAT_MS) ? LONG_MS : REPEAT_MS;
    localparam int CNT_W  = $clog2(MAX_MS + 1);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_MS - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESSED   = 2'd1,
        LONG_HELD = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] hold_cnt_q;
    logic             short_q;
    logic             long_q;
    logic             held_q;
`ifdef REPEAT_PRESS_EN
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_MS - 1);
    logic [CNT_W-1:0] rep_cnt_q;
    logic             rep_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            short_q    <= 1'b0;
            long_q     <= 1'b0;
            held_q     <= 1'b0;
`ifdef REPEAT_PRESS_EN
            rep_cnt_q  <= '0;
            rep_q      <= 1'b0;
`endif
        end else begin
            short_q <= 1'b0;
            long_q  <= 1'b0;
`ifdef REPEAT_PRESS_EN
            rep_q   <= 1'b0;
`endif
            // A same-cycle press+release is treated as noise: nothing moves.
            if (!(bus.pedge && bus.nedge)) begin
                case (state_q)
                    IDLE: begin
                        if (bus.pedge) begin
                            state_q    <= PRESSED;
                            hold_cnt_q <= '0;
                            held_q     <= 1'b1;
                        end
                    end
                    PRESSED: begin
                        if (bus.nedge) begin
                            state_q    <= IDLE;
                            short_q    <= 1'b1;
                            held_q     <= 1'b0;
                            hold_cnt_q <= '0;
                        end else if (bus.tick) begin
                            if (hold_cnt_q == LONG_LAST) begin
                                state_q    <= LONG_HELD;
                                long_q     <= 1'b1;
                                hold_cnt_q <= '0;
`ifdef REPEAT_PRESS_EN
                                rep_cnt_q  <= '0;
`endif
                            end else if (hold_cnt_q != CNT_MAX) begin
                                hold_cnt_q <= hold_cnt_q + 1'b1;
                            end
                        end
                    end
                    LONG_HELD: begin
                        if (bus.nedge) begin
                            state_q <= IDLE;
                            held_q  <= 1'b0;
`ifdef REPEAT_PRESS_EN
                            rep_cnt_q <= '0;
                        end else if (bus.tick) begin
                            if (rep_cnt_q == REP_LAST) begin
                                rep_q     <= 1'b1;
                                rep_cnt_q <= '0;
                            end else if (rep_cnt_q != CNT_MAX) begin
                                rep_cnt_q <= rep_cnt_q + 1'b1;
                            end
`endif
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        held_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.short_press = short_q;
    assign bus.long_press  = long_q;
    assign bus.held        = held_q;
    assign bus.state_dbg   = state_q;
`ifdef REPEAT_PRESS_EN
    assign bus.repeat_press = rep_q;
`else
    assign bus.repeat_press = 1'b0;
`endif
endmodule

// File: tb/tb_button_press_classifier.sv
// Directed bench for button_press_classifier with LONG_MS=5, REPEAT_MS=2, tick every 4 clk.
// Build with REPEAT_PRESS_EN defined to exercise auto-repeat expectations.
module tb_button_press_classifier;
    localparam int LONG_MS   = 5;
    localparam int REPEAT_MS = 2;
    localparam logic [1:0] ST_IDLE = 2'd0, ST_PRESSED = 2'd1, ST_LONG = 2'd2;
`ifdef REPEAT_PRESS_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    button_press_classifier_if bus ();

    button_press_classifier #(.LONG_MS(LONG_MS), .REPEAT_MS(REPEAT_MS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int sp_cnt = 0, lp_cnt = 0, rp_cnt = 0, held_cnt = 0, multi_cnt = 0;

    // Pulse/level tallies sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.short_press === 1'b1) sp_cnt++;
        if (bus.long_press === 1'b1) lp_cnt++;
        if (bus.repeat_press === 1'b1) rp_cnt++;
        if (bus.held === 1'b1) held_cnt++;
        if (int'(bus.short_press) + int'(bus.long_press) + int'(bus.repeat_press) > 1) multi_cnt++;
    end

    task automatic clear_counts();
        sp_cnt = 0; lp_cnt = 0; rp_cnt = 0; held_cnt = 0;
    endtask

    task automatic step(input logic t, input logic p, input logic n);
        bus.tick = t; bus.pedge = p; bus.nedge = n;
        @(posedge clk);
        #1;
        bus.tick = 1'b0; bus.pedge = 1'b0; bus.nedge = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            repeat (3) step(1'b0, 1'b0, 1'b0);
            step(1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic test_reset();
        bus.tick = 1'b0; bus.pedge = 1'b0; bus.nedge = 1'b0;
        #2;
        checks++;
        if (bus.state_dbg !== ST_IDLE || bus.held !== 1'b0 || bus.short_press !== 1'b0 ||
            bus.long_press !== 1'b0 || bus.repeat_press !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: state=%0d held=%b sp=%b lp=%b rp=%b, want all 0",
                     bus.state_dbg, bus.held, bus.short_press, bus.long_press, bus.repeat_press);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        step(1'b0, 1'b0, 1'b1);
        checks++;
        if (bus.state_dbg !== ST_IDLE || bus.short_press !== 1'b0) begin
            errors++;
            $display("FAIL nedge_after_reset: state=%0d sp=%b want 0 0", bus.state_dbg, bus.short_press);
        end
    endtask

    task automatic test_short_press();
        clear_counts();
        step(1'b0, 1'b1, 1'b0);
        checks++;
        if (bus.held !== 1'b1 || bus.state_dbg !== ST_PRESSED) begin
            errors++;
            $display("FAIL short_enter: held=%b state=%0d want 1 1", bus.held, bus.state_dbg);
        end
        ticks(3);
        step(1'b0, 1'b0, 1'b1);
        checks++;
        if (bus.short_press !== 1'b1 || bus.held !== 1'b0 || bus.state_dbg !== ST_IDLE) begin
            errors++;
            $display("FAIL short_pulse: sp=%b held=%b state=%0d want 1 0 0",
                     bus.short_press, bus.held, bus.state_dbg);
        end
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.short_press !== 1'b0) begin
            errors++;
            $display("FAIL short_width: sp=%b want 0", bus.short_press);
        end
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if (sp_cnt !== 1 || lp_cnt !== 0 || held_cnt !== 13) begin
            errors++;
            $display("FAIL short_counts: sp=%0d lp=%0d held=%0d want 1 0 13", sp_cnt, lp_cnt, held_cnt);
        end
    endtask

    task automatic test_long_press();
        clear_counts();
        step(1'b0, 1'b1, 1'b0);
        ticks(4);
        checks++;
        if (bus.long_press !== 1'b0 || bus.state_dbg !== ST_PRESSED) begin
            errors++;
            $display("FAIL long_early: lp=%b state=%0d want 0 1", bus.long_press, bus.state_dbg);
        end
        ticks(1);
        checks++;
        if (bus.long_press !== 1'b1 || bus.state_dbg !== ST_LONG || bus.held !== 1'b1) begin
            errors++;
            $display("FAIL long_pulse: lp=%b state=%0d held=%b want 1 2 1",
                     bus.long_press, bus.state_dbg, bus.held);
        end
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.long_press !== 1'b0) begin
            errors++;
            $display("FAIL long_width: lp=%b want 0", bus.long_press);
        end
        step(1'b0, 1'b0, 1'b1);
        checks++;
        if (bus.held !== 1'b0 || bus.short_press !== 1'b0 || bus.state_dbg !== ST_IDLE) begin
            errors++;
            $display("FAIL long_release: held=%b sp=%b state=%0d want 0 0 0",
                     bus.held, bus.short_press, bus.state_dbg);
        end
        repeat (2) step(1'b0, 1'b0, 1'b0);
        checks++;
        if (sp_cnt !== 0 || lp_cnt !== 1 || rp_cnt !== 0) begin
            errors++;
            $display("FAIL long_counts: sp=%0d lp=%0d rp=%0d want 0 1 0", sp_cnt, lp_cnt, rp_cnt);
        end
    endtask

    task automatic test_repeat();
        logic exp_rp;
        clear_counts();
        step(1'b0, 1'b1, 1'b0);
        ticks(5);
        for (int k = 6; k <= 9; k++) begin
            ticks(1);
            exp_rp = REP_EN && (k == 7 || k == 9);
            checks++;
            if (bus.repeat_press !== exp_rp || bus.state_dbg !== ST_LONG) begin
                errors++;
                $display("FAIL repeat_tick%0d: rp=%b state=%0d want %b 2",
                         k, bus.repeat_press, bus.state_dbg, exp_rp);
            end
        end
        step(1'b0, 1'b0, 1'b1);
        repeat (2) step(1'b0, 1'b0, 1'b0);
        checks++;
        if (rp_cnt !== (REP_EN ? 2 : 0) || lp_cnt !== 1 || sp_cnt !== 0) begin
            errors++;
            $display("FAIL repeat_counts: rp=%0d lp=%0d sp=%0d want %0d 1 0",
                     rp_cnt, lp_cnt, sp_cnt, REP_EN ? 2 : 0);
        end
    endtask

    task automatic test_both_edges();
        clear_counts();
        step(1'b0, 1'b1, 1'b1);
        checks++;
        if (bus.state_dbg !== ST_IDLE || bus.held !== 1'b0) begin
            errors++;
            $display("FAIL both_idle: state=%0d held=%b want 0 0", bus.state_dbg, bus.held);
        end
        step(1'b0, 1'b1, 1'b0);
        ticks(2);
        step(1'b0, 1'b1, 1'b1);
        checks++;
        if (bus.state_dbg !== ST_PRESSED || bus.held !== 1'b1 || bus.short_press !== 1'b0) begin
            errors++;
            $display("FAIL both_pressed: state=%0d held=%b sp=%b want 1 1 0",
                     bus.state_dbg, bus.held, bus.short_press);
        end
        step(1'b0, 1'b1, 1'b0);
        ticks(2);
        checks++;
        if (bus.long_press !== 1'b0 || bus.state_dbg !== ST_PRESSED) begin
            errors++;
            $display("FAIL both_tick4: lp=%b state=%0d want 0 1", bus.long_press, bus.state_dbg);
        end
        ticks(1);
        checks++;
        if (bus.long_press !== 1'b1) begin
            errors++;
            $display("FAIL both_tick5: lp=%b want 1", bus.long_press);
        end
        step(1'b0, 1'b0, 1'b1);
        repeat (2) step(1'b0, 1'b0, 1'b0);
        checks++;
        if (sp_cnt !== 0 || lp_cnt !== 1) begin
            errors++;
            $display("FAIL both_counts: sp=%0d lp=%0d want 0 1", sp_cnt, lp_cnt);
        end
    endtask

    task automatic test_coincident_release();
        clear_counts();
        step(1'b0, 1'b1, 1'b0);
        ticks(4);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        checks++;
        if (bus.short_press !== 1'b1 || bus.long_press !== 1'b0 || bus.state_dbg !== ST_IDLE) begin
            errors++;
            $display("FAIL coincident: sp=%b lp=%b state=%0d want 1 0 0",
                     bus.short_press, bus.long_press, bus.state_dbg);
        end
        repeat (2) step(1'b0, 1'b0, 1'b0);
        checks++;
        if (sp_cnt !== 1 || lp_cnt !== 0) begin
            errors++;
            $display("FAIL coincident_counts: sp=%0d lp=%0d want 1 0", sp_cnt, lp_cnt);
        end
    endtask

    task automatic test_reset_mid_press();
        clear_counts();
        step(1'b0, 1'b1, 1'b0);
        ticks(2);
        checks++;
        if (bus.held !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pre: held=%b want 1", bus.held);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (bus.held !== 1'b0 || bus.state_dbg !== ST_IDLE || bus.short_press !== 1'b0 ||
            bus.long_press !== 1'b0 || bus.repeat_press !== 1'b0) begin
            errors++;
            $display("FAIL midreset_async: held=%b state=%0d sp=%b lp=%b rp=%b want all 0",
                     bus.held, bus.state_dbg, bus.short_press, bus.long_press, bus.repeat_press);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        step(1'b0, 1'b0, 1'b1);
        checks++;
        if (bus.short_press !== 1'b0 || bus.state_dbg !== ST_IDLE) begin
            errors++;
            $display("FAIL midreset_nedge: sp=%b state=%0d want 0 0", bus.short_press, bus.state_dbg);
        end
        ticks(6);
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if (sp_cnt !== 0 || lp_cnt !== 0 || bus.state_dbg !== ST_IDLE) begin
            errors++;
            $display("FAIL midreset_counts: sp=%0d lp=%0d state=%0d want 0 0 0",
                     sp_cnt, lp_cnt, bus.state_dbg);
        end
    endtask

    initial begin
        test_reset();
        test_short_press();
        test_long_press();
        test_repeat();
        test_both_edges();
        test_coincident_release();
        test_reset_mid_press();
        checks++;
        if (multi_cnt !== 0) begin
            errors++;
            $display("FAIL exclusive_pulses: overlapping cycles=%0d want 0", multi_cnt);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/button_press_classifier.md
BUTTON_PRESS_CLASSIFIER -- requirements
Module: button_press_classifier

Interface
REQ-001 Parameter LONG_MS, default 1000, hold duration in ticks for a long press; legal range 2..65535.
REQ-002 Parameter REPEAT_MS, default 200, auto-repeat period in ticks while long-held; legal range 1..65535.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 tick  input  1  one-cycle time-base enable, nominally 1 ms; the only event that advances counters.
REQ-006 pedge  input  1  one-cycle pulse, button press, from upstream positive-edge detector.
REQ-007 nedge  input  1  one-cycle pulse, button release, from upstream negative-edge detector.
REQ-008 short_press  output  1  one-cycle pulse, released before LONG_MS ticks.
REQ-009 long_press  output  1  one-cycle pulse, hold reached LONG_MS ticks.
REQ-010 repeat_press  output  1  one-cycle pulse every REPEAT_MS ticks after long_press while held.
REQ-011 held  output  1  level, high while the FSM is in PRESSED or LONG_HELD.

Function
REQ-012 FSM states: IDLE, PRESSED, LONG_HELD; all outputs registered.
REQ-013 IDLE: pedge=1 and nedge=0 -> PRESSED, hold counter cleared to 0.
REQ-014 PRESSED: each tick increments the hold counter; on the tick where the counter equals LONG_MS-1 -> LONG_HELD, long_press=1 next cycle, counter cleared.
REQ-015 PRESSED: nedge=1 -> IDLE, short_press=1 next cycle; nedge takes priority over a same-cycle tick, so no long_press is issued.
REQ-016 LONG_HELD: nedge=1 -> IDLE, no short_press, no long_press, no repeat_press.
REQ-017 Output latency: exactly 1 clk after the qualifying input cycle; each pulse is exactly 1 clk wide.
REQ-018 Simultaneous pedge=1 and nedge=1 in any state: both ignored, state and counters unchanged.
REQ-019 pedge in PRESSED or LONG_HELD: ignored, counter not restarted.
REQ-020 nedge in IDLE: ignored.
REQ-021 Counter width: $clog2(max(LONG_MS, REPEAT_MS)+1) bits; the counter never wraps, and it saturates if tick persists without a transition.
REQ-022 held=1 from the cycle after entry to PRESSED through the cycle of the transition to IDLE, then held=0.
REQ-023 At most one of short_press, long_press, repeat_press is high in any cycle.

Reset
REQ-024 Reset forces IDLE, clears counters, and drives short_press, long_press, repeat_press and held to 0 immediately, without waiting for clk.
REQ-025 Reset asserted mid-press aborts the press; after release of reset, a fresh pedge is required before any output pulse.
REQ-026 An nedge in the first cycle after reset release is ignored (IDLE).

Configuration
REQ-027 Macro REPEAT_PRESS_EN defined: in LONG_HELD, each tick increments the repeat counter; on the tick where it equals REPEAT_MS-1, repeat_press=1 next cycle and the counter clears; nedge in the same cycle suppresses the pulse.
REQ-028 Macro REPEAT_PRESS_EN undefined: no repeat counter is synthesized, repeat_press is tied to 0, and LONG_HELD waits only for nedge.

Verification
Bench uses LONG_MS=5, REPEAT_MS=2, and tick every 4 clk.
REQ-029 pedge, 3 ticks, nedge -> short_press single pulse 1 clk after nedge; long_press never asserted; held high 3 ticks' duration.
REQ-030 pedge, hold 5 ticks -> long_press pulse 1 clk after the 5th tick; release -> no short_press, held falls.
REQ-031 REPEAT_PRESS_EN, pedge, hold 9 ticks -> long_press after tick 5, repeat_press after ticks 7 and 9; undefined -> repeat_press stays 0.
REQ-032 pedge and nedge both high in the same cycle while IDLE -> state stays IDLE, held=0, no pulses; repeat while PRESSED -> counter keeps counting.
REQ-033 pedge, 4 ticks, then nedge coincident with the 5th tick -> short_press only, no long_press.
REQ-034 pedge, 2 ticks, then async reset pulse mid-cycle -> held and all outputs 0 immediately; subsequent nedge -> no short_press.
